// File: rtl/sample_slot_ctrl_pkg.sv
// Shared types and constants for the periodic sample slot controller.
// FSM state, period clamp floor and address nibble select encodings.
package sample_slot_ctrl_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] PERIOD_MIN = 4'd2;

  localparam logic SEL_HI  = 1'b0;
  localparam logic SEL_MID = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] clamp_period(
    input logic [CNT_W-1:0] p
  );
    return (p < PERIOD_MIN) ? PERIOD_MIN : p;
  endfunction

endpackage

// File: rtl/sample_slot_ctrl_if.sv
// Source/consumer bundle of the sample slot controller.
// master drives data, config and ack; slave is the controller.
interface sample_slot_ctrl_if #(
  parameter int OVF_W = 8
);
  logic             x;
  logic [15:0]      d15_d0;
  logic             cfg_we;
  logic [3:0]       cfg_period;
  logic             ack;
  logic [7:0]       z7_z0;
  logic [3:0]       a3_a0;
  logic             valid;
  logic [OVF_W-1:0] ovf_cnt;

  modport master (
    output x, d15_d0, cfg_we, cfg_period, ack,
    input  z7_z0, a3_a0, valid, ovf_cnt
  );

  modport slave (
    input  x, d15_d0, cfg_we, cfg_period, ack,
    output z7_z0, a3_a0, valid, ovf_cnt
  );
endinterface

// File: rtl/sample_slot_ctrl_period_timer.sv
// Down-counting sample timer with run-time period register.
// A period write lands in period_q and only shapes the next reload.
module sample_slot_ctrl_period_timer
  import sample_slot_ctrl_pkg::*;
#(
  parameter int PERIOD = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign tick_o = (count_q == '0);

  always_comb begin
    period_d = period_q;
    if (cfg_we_i) period_d = clamp_period(cfg_period_i);
  end

  // Reload sees period_d so a write on the tick edge applies at once.
  always_comb begin
    count_d = count_q - 4'd1;
    if (tick_o) count_d = period_d - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q <= CNT_W'(PERIOD);
      count_q  <= CNT_W'(PERIOD - 1);
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sample_slot_ctrl.sv
// Periodic sampler: captures a data byte and address nibble every
// period, offers it with valid/ack and counts samples lost to overrun.
module sample_slot_ctrl
  import sample_slot_ctrl_pkg::*;
#(
  parameter int PERIOD = 10,
  parameter int OVF_W  = 8
) (
  input logic              clock,
  input logic              reset,
  sample_slot_ctrl_if.slave bus
);

  localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

  logic       tick;
  state_e     state_q, state_d;
  logic       cap, ovf_inc;
  logic [7:0] z_q, z_d;
  logic [3:0] a_q, a_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  sample_slot_ctrl_period_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk_i       (clock),
    .rst_i       (reset),
    .cfg_we_i    (bus.cfg_we),
    .cfg_period_i(bus.cfg_period),
    .tick_o      (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (tick) state_d = FULL;
      FULL:  if (bus.ack && !tick) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // A tick while FULL and unacked keeps the old sample.
  always_comb begin
    cap     = tick && ((state_q == EMPTY) || bus.ack);
    ovf_inc = tick && (state_q == FULL) && !bus.ack;
  end

  always_comb begin
    z_d   = z_q;
    a_d   = a_q;
    ovf_d = ovf_q;
    if (cap) begin
      z_d = bus.d15_d0[7:0];
      a_d = (bus.x == SEL_MID) ? bus.d15_d0[11:8]
                               : bus.d15_d0[15:12];
    end
    if (ovf_inc && ovf_q != OVF_MAX)
      ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      z_q   <= '0;
      a_q   <= '0;
      ovf_q <= '0;
    end else begin
      z_q   <= z_d;
      a_q   <= a_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.z7_z0   = z_q;
  assign bus.a3_a0   = a_q;
  assign bus.valid   = (state_q == FULL);
  assign bus.ovf_cnt = ovf_q;

endmodule
